// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: owns the PC, drives imem, registers the fetched word for decode
// Redirects flush the output slot; a misaligned redirect target halts fetch until reset.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rd,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_plus4,
   output logic            misalign_err
);

   typedef enum logic [1:0] {START, RUN, HALT} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt, pc_plus4;
   logic [XLEN-1:0] instr_q, instr_nxt, opc_q, opc_nxt, opc4_q, opc4_nxt;
   logic            valid_q, valid_nxt, err_q, err_nxt;
   logic            redirect_bad, slot_free;

   assign pc_plus4     = pc + XLEN'(4);
   assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
   assign slot_free    = !valid_q || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= START;
         pc      <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= '0;
         opc_q   <= '0;
         opc4_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         valid_q <= valid_nxt;
         instr_q <= instr_nxt;
         opc_q   <= opc_nxt;
         opc4_q  <= opc4_nxt;
         err_q   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         START:   state_nxt = redirect_bad ? HALT : RUN;
         RUN:     if (redirect_bad) state_nxt = HALT;
         HALT:    state_nxt = HALT;
         default: state_nxt = HALT;
      endcase
   end

   // START only differs from RUN in that the imem word is not captured yet.
   always_comb begin
      pc_nxt    = pc;
      valid_nxt = valid_q;
      instr_nxt = instr_q;
      opc_nxt   = opc_q;
      opc4_nxt  = opc4_q;
      err_nxt   = err_q;
      if (state != HALT) begin
         if (redirect_bad) begin
            err_nxt   = 1'b1;
            valid_nxt = 1'b0;
         end else if (redirect_valid) begin
            pc_nxt    = redirect_target;
            valid_nxt = 1'b0;
         end else if (state == RUN && slot_free) begin
            instr_nxt = imem_rd;
            opc_nxt   = pc;
            opc4_nxt  = pc_plus4;
            valid_nxt = 1'b1;
            pc_nxt    = pc_plus4;
         end
      end
   end

   assign imem_addr    = pc;
   assign out_valid    = valid_q;
   assign out_instr    = instr_q;
   assign out_pc       = opc_q;
   assign out_pc_plus4 = opc4_q;
   assign misalign_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
// a0 uses RESET_PC=0, a1 uses RESET_PC=0x40; both share clock, reset and stimulus.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        out_ready = 1'b0;

   logic [31:0] a0_addr, a0_rd, a0_instr, a0_pc, a0_pc4;
   logic        a0_valid, a0_err;
   logic [31:0] a1_addr, a1_rd, a1_instr, a1_pc, a1_pc4;
   logic        a1_valid, a1_err;

   assign a0_rd = 32'hA000_0000 | a0_addr;
   assign a1_rd = 32'hA000_0000 | a1_addr;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut0 (
      .clk(clk), .rst(rst), .imem_addr(a0_addr), .imem_rd(a0_rd),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .out_ready(out_ready), .out_valid(a0_valid), .out_instr(a0_instr),
      .out_pc(a0_pc), .out_pc_plus4(a0_pc4), .misalign_err(a0_err)
   );

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0040)) dut1 (
      .clk(clk), .rst(rst), .imem_addr(a1_addr), .imem_rd(a1_rd),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .out_ready(out_ready), .out_valid(a1_valid), .out_instr(a1_instr),
      .out_pc(a1_pc), .out_pc_plus4(a1_pc4), .misalign_err(a1_err)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] sb_pc;
   logic [31:0] sb_instr;
   logic [31:0] sb_pc4;
   logic [31:0] saved_addr;

   // Inputs only change just after posedge, so a negedge handshake is final.
   always @(negedge clk) begin
      if (!rst && a0_valid && out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got out_pc=%h, expected no output", a0_pc);
         end else begin
            sb_pc    = exp_q.pop_front();
            sb_instr = 32'hA000_0000 | sb_pc;
            sb_pc4   = sb_pc + 32'd4;
            if (a0_pc !== sb_pc || a0_instr !== sb_instr || a0_pc4 !== sb_pc4) begin
               bad++;
               $display("FAIL sb_output: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                        a0_pc, a0_instr, a0_pc4, sb_pc, sb_instr, sb_pc4);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_out(input logic [31:0] pc);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(a0_valid === 1'b1 && a0_pc === pc) && n < 30);
      total++;
      if (!(a0_valid === 1'b1 && a0_pc === pc)) begin
         bad++;
         $display("FAIL wait_out: got valid=%b pc=%h, expected valid=1 pc=%h", a0_valid, a0_pc, pc);
      end
   endtask

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         tick();
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL wait_empty: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (a0_valid !== 1'b0 || a0_err !== 1'b0 || a0_addr !== 32'h0 ||
          a0_pc !== 32'h0 || a0_instr !== 32'h0 || a0_pc4 !== 32'h0) begin
         bad++;
         $display("FAIL reset_state: got v=%b e=%b addr=%h pc=%h instr=%h pc4=%h, expected all 0",
                  a0_valid, a0_err, a0_addr, a0_pc, a0_instr, a0_pc4);
      end
      total++;
      if (a1_addr !== 32'h40) begin
         bad++;
         $display("FAIL reset_pc_param: got %h, expected 00000040", a1_addr);
      end
   endtask

   task automatic test_stream();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      out_ready = 1'b1;
      tick();
      total++;
      if (a0_valid !== 1'b0) begin
         bad++;
         $display("FAIL start_no_valid: got %b, expected 0", a0_valid);
      end
      wait_out(32'h8);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL stream_drained: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (a0_valid !== 1'b1 || a0_instr !== 32'hA000_0008 || a0_pc !== 32'h8 || a0_addr !== 32'hC) begin
            bad++;
            $display("FAIL stall_hold: got v=%b instr=%h pc=%h addr=%h, expected 1 A0000008 8 C",
                     a0_valid, a0_instr, a0_pc, a0_addr);
         end
      end
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      out_ready = 1'b1;
      wait_empty();
      out_ready = 1'b0;
   endtask

   task automatic test_redirect();
      do_reset();
      out_ready = 1'b1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      wait_out(32'h4);
      redirect_valid = 1'b1;
      redirect_target = 32'h0000_0100;
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h104);
      exp_q.push_back(32'h108);
      tick();
      redirect_valid = 1'b0;
      total++;
      if (a0_valid !== 1'b0 || a0_addr !== 32'h100) begin
         bad++;
         $display("FAIL redirect_flush: got v=%b addr=%h, expected 0 100", a0_valid, a0_addr);
      end
      tick();
      total++;
      if (a0_valid !== 1'b1 || a0_pc !== 32'h100 || a0_instr !== 32'hA000_0100) begin
         bad++;
         $display("FAIL redirect_first: got v=%b pc=%h instr=%h, expected 1 100 A0000100",
                  a0_valid, a0_pc, a0_instr);
      end
      wait_empty();
      out_ready = 1'b0;
   endtask

   task automatic test_misalign();
      do_reset();
      out_ready = 1'b1;
      exp_q.push_back(32'h0);
      wait_out(32'h0);
      saved_addr = a0_addr;
      redirect_valid = 1'b1;
      redirect_target = 32'h0000_0102;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 11; i++) begin
         total++;
         if (a0_err !== 1'b1 || a0_valid !== 1'b0 || a0_addr !== saved_addr || saved_addr !== 32'h4) begin
            bad++;
            $display("FAIL halt_state: cycle %0d got e=%b v=%b addr=%h, expected 1 0 4",
                     i, a0_err, a0_valid, a0_addr);
         end
         tick();
      end
      do_reset();
      total++;
      if (a0_err !== 1'b0 || a0_addr !== 32'h0 || a0_valid !== 1'b0) begin
         bad++;
         $display("FAIL halt_reset: got e=%b addr=%h v=%b, expected 0 0 0", a0_err, a0_addr, a0_valid);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      redirect_valid = 1'b1;
      redirect_target = 32'hFFFF_FFF8;
      out_ready = 1'b1;
      exp_q.push_back(32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0000_0000);
      tick();
      redirect_valid = 1'b0;
      total++;
      if (a0_valid !== 1'b0 || a0_addr !== 32'hFFFF_FFF8) begin
         bad++;
         $display("FAIL start_redirect: got v=%b addr=%h, expected 0 FFFFFFF8", a0_valid, a0_addr);
      end
      wait_out(32'hFFFF_FFFC);
      total++;
      if (a0_pc4 !== 32'h0 || a0_err !== 1'b0) begin
         bad++;
         $display("FAIL wrap_pc4: got pc4=%h e=%b, expected 0 0", a0_pc4, a0_err);
      end
      wait_empty();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      out_ready = 1'b1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      wait_out(32'hC);
      out_ready = 1'b0;
      tick();
      total++;
      if (a0_valid !== 1'b1 || a0_pc !== 32'hC) begin
         bad++;
         $display("FAIL pre_reset_stall: got v=%b pc=%h, expected 1 C", a0_valid, a0_pc);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (a1_valid !== 1'b0 || a1_addr !== 32'h40 || a0_valid !== 1'b0 || a0_addr !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset: got v1=%b addr1=%h v0=%b addr0=%h, expected 0 40 0 0",
                  a1_valid, a1_addr, a0_valid, a0_addr);
      end
      out_ready = 1'b1;
      tick();
      tick();
      total++;
      if (a1_valid !== 1'b1 || a1_pc !== 32'h40 || a1_instr !== 32'hA000_0040 || a1_pc4 !== 32'h44) begin
         bad++;
         $display("FAIL reset_pc_first: got v=%b pc=%h instr=%h pc4=%h, expected 1 40 A0000040 44",
                  a1_valid, a1_pc, a1_instr, a1_pc4);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_misalign();
      test_wrap();
      test_reset_mid_stall();
      tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL final_queue: got %0d pending, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
